exp_sched: RTL and testbench

EXP_SCHED -- requirements
Module: exp_sched

---
 rtl/exp_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/exp_sched.sv | 166 ++++++++++++++++
 tb/tb_exp_sched.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exp_pkg.sv
// exp_pkg: shared definitions for the exponent-engine scheduler.
//   - state_t     : scheduler FSM state encoding (IDLE encodes to 0)
//   - W_DEF       : default operand/result width
//   - N_REQ_DEF   : default number of requesters
//   - TIMEOUT_DEF : default maximum number of WAIT cycles before abort
package exp_pkg;

  localparam int W_DEF       = 16;
  localparam int N_REQ_DEF   = 4;
  localparam int TIMEOUT_DEF = 1024;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GRANT    = 3'd1,
    S_DISPATCH = 3'd2,
    S_WAIT     = 3'd3,
    S_RESPOND  = 3'd4
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin selector.
// The search starts at requester (last_served+1) mod N_REQ and wraps around.
// Ports:
//   req         in  N_REQ  request vector
//   last_served in  IW     index of the most recently served requester
//   grant       out N_REQ  one-hot winner (all zero when req is zero)
//   index       out IW     binary index of the winner (0 when req is zero)
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_served,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    index
);

  int          w_pos;
  logic [IW-1:0] w_pos_idx;
  logic        w_found;

  always_comb begin
    grant     = '0;
    index     = '0;
    w_found   = 1'b0;
    w_pos     = 0;
    w_pos_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      // last_served < N_REQ and 1+k <= N_REQ, so one subtraction wraps it
      w_pos = int'(last_served) + 1 + k;
      if (w_pos >= N_REQ) w_pos = w_pos - N_REQ;
      w_pos_idx = IW'(w_pos);
      if (!w_found && req[w_pos_idx]) begin
        w_found          = 1'b1;
        grant[w_pos_idx] = 1'b1;
        index            = w_pos_idx;
      end
    end
  end

endmodule

// File: rtl/exp_sched.sv
// exp_sched: shares one external exponent engine among N_REQ requesters.
// One job is in flight at a time: IDLE -> GRANT -> DISPATCH -> WAIT -> RESPOND.
// Handshake: a requester holds req[i] high with stable req_c/req_j slices
// until it sees the one-cycle gnt[i] pulse, at which point its operands have
// been captured; its result later arrives as a one-cycle rsp_valid[i] pulse
// with rsp_g/rsp_err valid only in that cycle (both read 0 otherwise).
// Toward the engine, eng_start is a one-cycle pulse with eng_c/eng_j held
// stable until eng_done (a one-cycle pulse carrying eng_g) or eng_abort.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req, req_c, req_j     per-requester request level and operands
//   gnt, rsp_valid        one-hot grant pulse / one-hot response pulse
//   rsp_g, rsp_err        response result and error flag
//   eng_start, eng_c,
//   eng_j, eng_abort      engine control and operands
//   eng_done, eng_g       engine completion pulse and result
//   dbg_state             current FSM state (state_t encoding)
module exp_sched
  import exp_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int W       = W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] req_c,
  input  logic [N_REQ*W-1:0] req_j,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [W-1:0]       rsp_g,
  output logic               rsp_err,
  output logic               eng_start,
  output logic [W-1:0]       eng_c,
  output logic [W-1:0]       eng_j,
  input  logic               eng_done,
  input  logic [W-1:0]       eng_g,
  output logic               eng_abort,
  output logic [2:0]         dbg_state
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t             r_state;
  state_t             w_next;
  logic [W-1:0]       r_c;
  logic [W-1:0]       r_j;
  logic [N_REQ-1:0]   r_sel;
  logic [IW-1:0]      r_idx;
  logic [IW-1:0]      r_last;
  logic [W-1:0]       r_g;
  logic               r_err;
  logic [CW-1:0]      r_cnt;

  logic [N_REQ-1:0]   w_grant;
  logic [IW-1:0]      w_idx;
  logic [W-1:0]       w_c;
  logic [W-1:0]       w_j;
  logic               w_c_le1;
  logic               w_timeout;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_arb (
    .req         (req),
    .last_served (r_last),
    .grant       (w_grant),
    .index       (w_idx)
  );

  // Operand mux driven by the one-hot arbiter grant
  always_comb begin
    w_c = '0;
    w_j = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_c = req_c[i*W +: W];
        w_j = req_j[i*W +: W];
      end
    end
  end

  // A base of 0 or 1 can never grow past j, so such jobs are rejected
  assign w_c_le1   = (r_c <= W'(1));
  assign w_timeout = (r_state == S_WAIT) && (r_cnt == CW'(TIMEOUT - 1));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // FSM next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (|req) w_next = S_GRANT;
      S_GRANT:    w_next = w_c_le1 ? S_RESPOND : S_DISPATCH;
      S_DISPATCH: w_next = S_WAIT;
      S_WAIT:     if (eng_done || w_timeout) w_next = S_RESPOND;
      S_RESPOND:  w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Job datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c    <= '0;
      r_j    <= '0;
      r_sel  <= '0;
      r_idx  <= '0;
      r_g    <= '0;
      r_err  <= 1'b0;
      r_cnt  <= '0;
      r_last <= IW'(N_REQ - 1);
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_c   <= w_c;
            r_j   <= w_j;
            r_sel <= w_grant;
            r_idx <= w_idx;
          end
        end
        S_GRANT: begin
          if (w_c_le1) begin
            r_g   <= '0;
            r_err <= 1'b1;
          end
        end
        S_DISPATCH: r_cnt <= '0;
        S_WAIT: begin
          // Completion takes priority over a timeout in the same cycle
          if (eng_done) begin
            r_g   <= eng_g;
            r_err <= 1'b0;
          end else if (w_timeout) begin
            r_g   <= '1;
            r_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RESPOND: r_last <= r_idx;
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state; all zero while in reset
  assign gnt       = (r_state == S_GRANT)   ? r_sel : '0;
  assign rsp_valid = (r_state == S_RESPOND) ? r_sel : '0;
  assign rsp_g     = (r_state == S_RESPOND) ? r_g   : '0;
  assign rsp_err   = (r_state == S_RESPOND) ? r_err : 1'b0;
  assign eng_start = (r_state == S_DISPATCH);
  assign eng_c     = r_c;
  assign eng_j     = r_j;
  assign eng_abort = w_timeout && !eng_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_exp_sched.sv
// tb_exp_sched: self-checking bench for exp_sched with a behavioural engine.
module tb_exp_sched;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int TO = 16;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_c;
  logic [N*W-1:0] req_j;
  logic [N-1:0]   gnt;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_g;
  logic           rsp_err;
  logic           eng_start;
  logic [W-1:0]   eng_c;
  logic [W-1:0]   eng_j;
  logic           eng_done;
  logic [W-1:0]   eng_g;
  logic           eng_abort;
  logic [2:0]     dbg_state;

  exp_sched #(.N_REQ(N), .W(W), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_c     (req_c),
    .req_j     (req_j),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_g     (rsp_g),
    .rsp_err   (rsp_err),
    .eng_start (eng_start),
    .eng_c     (eng_c),
    .eng_j     (eng_j),
    .eng_done  (eng_done),
    .eng_g     (eng_g),
    .eng_abort (eng_abort),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- counters / scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [20:0] exp_q[$];  // {rsp_valid, rsp_g, rsp_err}
  int n_rsp = 0, n_start = 0, n_abort = 0;
  int start_cyc = 0, abort_cyc = 0, done_cyc = 0, rsp_cyc = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  // ---------------- engine model ----------------
  int   eng_lat    = 1;     // done in WAIT cycle number eng_lat; 0 = never
  logic force_done = 1'b0;  // one stray done pulse
  logic e_busy     = 1'b0;
  int   e_cnt      = 0;
  logic [W-1:0] e_res = '0;

  function automatic logic [W-1:0] exp_model(input logic [W-1:0] c, input logic [W-1:0] j);
    longint t;
    int n;
    t = longint'(c);
    n = 0;
    if (c > 1) begin
      while (t < longint'(j)) begin
        t = t * longint'(c);
        n++;
      end
    end
    return W'(n);
  endfunction

  initial begin
    eng_done = 1'b0;
    eng_g    = '0;
  end

  always @(posedge clk) begin
    #2;
    eng_done = 1'b0;
    eng_g    = '0;
    if (!rst_n) begin
      e_busy = 1'b0;
    end else begin
      if (force_done) begin
        eng_done   = 1'b1;
        eng_g      = 16'h1234;
        force_done = 1'b0;
      end
      if (e_busy) begin
        if (e_cnt == 1) begin
          eng_done = 1'b1;
          eng_g    = e_res;
          e_busy   = 1'b0;
        end else if (e_cnt > 1) begin
          e_cnt--;
        end
      end
      if (eng_start) begin
        e_busy = 1'b1;
        e_cnt  = eng_lat;
        e_res  = exp_model(eng_c, eng_j);
      end
    end
  end

  // ---------------- monitor (samples on negedge) ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (eng_start) begin n_start++; start_cyc = cyc; end
      if (eng_abort) begin n_abort++; abort_cyc = cyc; end
      if (eng_done && dbg_state == 3'd3) done_cyc = cyc;
      if (rsp_valid != '0) begin
        n_rsp++;
        rsp_cyc = cyc;
        if (exp_q.size() == 0) fail_now("unexpected_rsp");
        else chk("rsp", {rsp_valid, rsp_g, rsp_err}, exp_q.pop_front());
      end else if (rsp_g != '0 || rsp_err != 1'b0) begin
        chk("rsp_idle_zero", {rsp_g, rsp_err}, '0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [N-1:0] r, input logic [W-1:0] c, input logic [W-1:0] j);
    for (int i = 0; i < N; i++) begin
      req_c[i*W +: W] = c;
      req_j[i*W +: W] = j;
    end
    req = r;
  endtask

  task automatic wait_gnt(output logic ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (gnt != '0) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_rsp(input int target);
    for (int k = 0; k < 80; k++) begin
      if (n_rsp >= target) return;
      tick();
    end
    if (n_rsp < target) fail_now("wait_rsp");
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_gnt"},       gnt,       '0);
    chk({tag, "_rsp_valid"}, rsp_valid, '0);
    chk({tag, "_rsp_g"},     rsp_g,     '0);
    chk({tag, "_rsp_err"},   rsp_err,   '0);
    chk({tag, "_eng_start"}, eng_start, '0);
    chk({tag, "_eng_abort"}, eng_abort, '0);
    chk({tag, "_eng_c"},     eng_c,     '0);
    chk({tag, "_eng_j"},     eng_j,     '0);
    chk({tag, "_state"},     dbg_state, '0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [N-1:0] req;
    logic [W-1:0] c;
    logic [W-1:0] j;
    int           lat;
    int           win;
    logic [W-1:0] g;
    logic         err;
    int           starts;
    int           aborts;
  } vec_t;

  vec_t vt[11];

  task automatic run_vec(input vec_t v, input int idx);
    int   s0, a0, r0;
    logic ok;
    s0 = n_start; a0 = n_abort; r0 = n_rsp;
    eng_lat = v.lat;
    set_req(v.req, v.c, v.j);
    exp_q.push_back({4'b0001 << v.win, v.g, v.err});
    wait_gnt(ok);
    if (!ok) fail_now($sformatf("vec%0d_gnt", idx));
    else chk($sformatf("vec%0d_gnt", idx), gnt, 4'b0001 << v.win);
    req = '0;
    wait_rsp(r0 + 1);
    chk($sformatf("vec%0d_starts", idx), n_start - s0, v.starts);
    chk($sformatf("vec%0d_aborts", idx), n_abort - a0, v.aborts);
    if (v.aborts == 1)
      chk($sformatf("vec%0d_abort_delay", idx), abort_cyc - start_cyc, TO);
    else if (v.starts == 1)
      chk($sformatf("vec%0d_rsp_after_done", idx), rsp_cyc - done_cyc, 1);
    tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic ok;
    int   r0;
    int   s0;

    rst_n = 1'b0;
    req   = '0;
    req_c = '0;
    req_j = '0;

    //               req      c      j      lat win g        err st ab
    vt[0]  = '{4'b0100, 16'd1, 16'd50,    1,  2, 16'd0,    1'b1, 0, 0};
    vt[1]  = '{4'b0010, 16'd0, 16'd7,     1,  1, 16'd0,    1'b1, 0, 0};
    vt[2]  = '{4'b1000, 16'd5, 16'd1000,  2,  3, 16'd4,    1'b0, 1, 0};
    vt[3]  = '{4'b0110, 16'd2, 16'd2,     1,  1, 16'd0,    1'b0, 1, 0};
    vt[4]  = '{4'b1001, 16'd2, 16'd65535, 4,  3, 16'd15,   1'b0, 1, 0};
    vt[5]  = '{4'b1100, 16'd3, 16'd81,    16, 2, 16'd3,    1'b0, 1, 0};
    vt[6]  = '{4'b0001, 16'd2, 16'd100,   0,  0, 16'hFFFF, 1'b1, 1, 1};
    vt[7]  = '{4'b1010, 16'd3, 16'd100,   15, 1, 16'd4,    1'b0, 1, 0};
    vt[8]  = '{4'b0101, 16'd7, 16'd49,    5,  2, 16'd1,    1'b0, 1, 0};
    vt[9]  = '{4'b1001, 16'd4, 16'd16,    2,  3, 16'd1,    1'b0, 1, 0};
    vt[10] = '{4'b0011, 16'd2, 16'd8,     1,  0, 16'd2,    1'b0, 1, 0};

    // Reset state
    tick();
    tick();
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Round-robin with all four requesters held: 0,1,2,3,0
    r0 = n_rsp;
    eng_lat = $urandom_range(1, 4);
    set_req(4'b1111, 16'd3, 16'd81);
    for (int n = 0; n < 5; n++) exp_q.push_back({4'b0001 << (n % 4), 16'd3, 1'b0});
    for (int n = 0; n < 5; n++) begin
      wait_gnt(ok);
      if (!ok) fail_now("rr_gnt");
      else chk($sformatf("rr_gnt%0d", n), gnt, 4'b0001 << (n % 4));
      if (n == 4) req = '0;
    end
    wait_rsp(r0 + 5);
    tick();

    // Latency: gnt one cycle after req, eng_start the cycle after that
    r0 = n_rsp;
    eng_lat = 3;
    set_req(4'b0001, 16'd2, 16'd100);
    exp_q.push_back({4'b0001, 16'd6, 1'b0});
    tick();
    chk("lat_gnt", gnt, 4'b0001);
    chk("lat_no_start_yet", eng_start, 1'b0);
    req = '0;
    tick();
    chk("lat_eng_start", eng_start, 1'b1);
    chk("lat_eng_c", eng_c, 16'd2);
    chk("lat_eng_j", eng_j, 16'd100);
    wait_rsp(r0 + 1);
    chk("lat_rsp_after_done", rsp_cyc - done_cyc, 1);
    tick();

    // Table
    for (int i = 0; i < 11; i++) run_vec(vt[i], i);

    // Stray eng_done while idle is ignored
    r0 = n_rsp;
    force_done = 1'b1;
    tick();
    tick();
    tick();
    chk("stray_done_no_rsp", n_rsp - r0, 0);
    chk("stray_done_idle", dbg_state, 3'd0);

    // Reset in the middle of a job (last served was requester 0)
    r0 = n_rsp;
    eng_lat = 0;
    set_req(4'b0010, 16'd2, 16'd100);
    wait_gnt(ok);
    if (!ok) fail_now("mid_gnt");
    else chk("mid_gnt", gnt, 4'b0010);
    req = '0;
    s0 = n_start;
    for (int k = 0; k < 6; k++) tick();
    chk("mid_in_wait", dbg_state, 3'd3);
    chk("mid_started", n_start - s0, 1);
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("mid_rst");
    tick();
    chk_zero_outputs("mid_rst_held");
    rst_n = 1'b1;
    tick();
    chk("mid_no_rsp", n_rsp - r0, 0);
    eng_lat = 1;
    set_req(4'b0011, 16'd5, 16'd30);
    exp_q.push_back({4'b0001, 16'd2, 1'b0});
    wait_gnt(ok);
    if (!ok) fail_now("post_rst_gnt");
    else chk("post_rst_gnt", gnt, 4'b0001);
    req = '0;
    wait_rsp(r0 + 1);
    tick();
    chk("exp_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
